// File: rtl/spi_frame_tx_if.sv
// Bundle of request and serial-line signals for the SPI frame transmitter.
interface spi_frame_tx_if;
  logic       start;
  logic [7:0] command;
  logic [7:0] databyte1;
  logic [7:0] databyte2;
  logic       busy;
  logic       done;
  logic       cs;
  logic       sck;
  logic       sdo;

  modport master (
    output start, command, databyte1, databyte2,
    input  busy, done, cs, sck, sdo
  );

  modport slave (
    input  start, command, databyte1, databyte2,
    output busy, done, cs, sck, sdo
  );
endinterface

// File: rtl/spi_frame_tx.sv
// Mode-0 SPI master that serialises one 24-bit {command, databyte1, databyte2} frame,
// deriving sck from clk with CLK_DIV system cycles per sck half-period.
module spi_frame_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           resetB,
  spi_frame_tx_if.slave  bus
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       LAST_BIT = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_bit;
  logic [23:0]      r_shift;
  logic             r_tail;
  logic             r_cs;
  logic             r_sck;
  logic             r_busy;
  logic             r_done;

  logic             w_div_end;
  logic [DIV_W-1:0] w_div_dec;

  assign w_div_end = (r_div == {DIV_W{1'b0}});
  assign w_div_dec = r_div - DIV_W'(1);

  // sdo is the shift register MSB, which is cleared in IDLE so the line rests low
  assign bus.cs   = r_cs;
  assign bus.sck  = r_sck;
  assign bus.sdo  = r_shift[23];
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // Frame sequencer: divider, bit counter, shift register and all line outputs
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      r_state <= S_IDLE;
      r_div   <= DIV_LOAD;
      r_bit   <= 5'd0;
      r_shift <= 24'd0;
      r_tail  <= 1'b0;
      r_cs    <= 1'b0;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        r_div <= w_div_end ? DIV_LOAD : w_div_dec;
      end else begin
        r_div <= DIV_LOAD;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_sck  <= 1'b0;
          if (bus.start) begin
            r_shift <= {bus.command, bus.databyte1, bus.databyte2};
            r_bit   <= 5'd0;
            r_tail  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end else begin
            r_shift <= 24'd0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_sck   <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_sck   <= 1'b0;
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            r_sck   <= 1'b0;
            r_state <= S_LOW;
            // The last bit leaves one trailing low half-period before HOLD
            if (r_bit == LAST_BIT) begin
              r_tail  <= 1'b1;
            end else begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_bit   <= r_bit + 5'd1;
            end
          end else begin
            r_sck   <= 1'b1;
          end
        end
        S_LOW: begin
          if (w_div_end) begin
            if (r_tail) begin
              r_state <= S_HOLD;
            end else begin
              r_sck   <= 1'b1;
              r_state <= S_HIGH;
            end
          end else begin
            r_sck   <= 1'b0;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_cs    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_shift <= 24'd0;
            r_state <= S_IDLE;
          end else begin
            r_sck   <= 1'b0;
          end
        end
        default: begin
          r_cs    <= 1'b0;
          r_sck   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_shift <= 24'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: a CLK_DIV=4 and a CLK_DIV=1 instance, a line monitor
// that decodes frames on sck rising edges, and a scoreboard of expected frames.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst1;

  spi_frame_tx_if if4 ();
  spi_frame_tx_if if1 ();

  spi_frame_tx #(.CLK_DIV(4)) u_dut4 (.clk(clk), .resetB(rst4), .bus(if4.slave));
  spi_frame_tx #(.CLK_DIV(1)) u_dut1 (.clk(clk), .resetB(rst1), .bus(if1.slave));

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [23:0] frame;
  } vec_t;

  vec_t vecs [5];

  logic [23:0] q4 [$];
  logic [23:0] q1 [$];

  // Line monitor state, index 0 = CLK_DIV 4 instance, 1 = CLK_DIV 1 instance
  logic        p_cs   [2] = '{1'b0, 1'b0};
  logic        p_sck  [2] = '{1'b0, 1'b0};
  logic        p_sdo  [2] = '{1'b0, 1'b0};
  logic        p_done [2] = '{1'b0, 1'b0};
  int          cs_len [2] = '{0, 0};
  int          edges  [2] = '{0, 0};
  int          gap    [2] = '{1000, 1000};
  int          done_cnt [2] = '{0, 0};
  logic [23:0] rx     [2];
  int          gmin = 1000;
  int          gmax = 0;
  int          gap_n = 0;

  logic        m_rst, m_cs, m_sck, m_sdo, m_busy, m_done, m_has;
  logic [23:0] m_exp;
  int          m_cd;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_rst  = (d == 0) ? rst4      : rst1;
      m_cs   = (d == 0) ? if4.cs    : if1.cs;
      m_sck  = (d == 0) ? if4.sck   : if1.sck;
      m_sdo  = (d == 0) ? if4.sdo   : if1.sdo;
      m_busy = (d == 0) ? if4.busy  : if1.busy;
      m_done = (d == 0) ? if4.done  : if1.done;
      m_cd   = (d == 0) ? 4 : 1;
      if (!m_rst) begin
        chk({m_cs, m_sck, m_sdo, m_busy, m_done} == 5'b0, "reset_outputs",
            {27'd0, m_cs, m_sck, m_sdo, m_busy, m_done}, 32'd0);
        if (p_cs[d]) begin
          if (d == 0 && q4.size() > 0) void'(q4.pop_front());
          if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end
        p_cs[d] = 1'b0; p_sck[d] = 1'b0; p_sdo[d] = 1'b0; p_done[d] = 1'b0;
        gap[d] = 1000;
      end else begin
        chk(m_busy == m_cs, "busy_vs_cs", {31'd0, m_busy}, {31'd0, m_cs});
        if (!m_cs) chk({m_sck, m_sdo} == 2'b00, "idle_sck_sdo", {30'd0, m_sck, m_sdo}, 32'd0);
        if (m_sck) chk(m_sdo == p_sdo[d], "sdo_stable_high", {31'd0, m_sdo}, {31'd0, p_sdo[d]});
        if (d == 1 && m_sck) chk(!p_sck[d], "sck_toggle", {31'd0, p_sck[d]}, 32'd0);
        if (m_done) begin
          done_cnt[d]++;
          chk(!p_done[d], "done_width", {31'd0, p_done[d]}, 32'd0);
        end
        if (m_cs) begin
          if (!p_cs[d]) begin
            cs_len[d] = 0;
            edges[d]  = 0;
            rx[d]     = 24'd0;
            if (gap[d] < 50) begin
              gap_n++;
              if (gap[d] < gmin) gmin = gap[d];
              if (gap[d] > gmax) gmax = gap[d];
            end
          end
          cs_len[d]++;
          if (m_sck && !p_sck[d]) begin
            edges[d]++;
            rx[d] = {rx[d][22:0], m_sdo};
            if (edges[d] == 1) chk(cs_len[d] == m_cd + 1, "first_rise", cs_len[d], m_cd + 1);
          end
        end else if (p_cs[d]) begin
          chk(m_done == 1'b1, "done_at_end", {31'd0, m_done}, 32'd1);
          chk(edges[d] == 24, "edge_count", edges[d], 32'd24);
          chk(cs_len[d] == 50 * m_cd, "cs_high_len", cs_len[d], 50 * m_cd);
          m_has = 1'b0;
          m_exp = 24'd0;
          if (d == 0 && q4.size() > 0) begin m_exp = q4.pop_front(); m_has = 1'b1; end
          if (d == 1 && q1.size() > 0) begin m_exp = q1.pop_front(); m_has = 1'b1; end
          if (m_has) chk(rx[d] == m_exp, "frame_data", {8'd0, rx[d]}, {8'd0, m_exp});
          else       chk(1'b0, "unexpected_frame", {8'd0, rx[d]}, 32'd0);
          gap[d] = 1;
        end else if (gap[d] < 1000) begin
          gap[d]++;
        end
        p_cs[d] = m_cs; p_sck[d] = m_sck; p_sdo[d] = m_sdo; p_done[d] = m_done;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic [23:0] f);
    if (d == 0) begin
      if4.command = c; if4.databyte1 = a; if4.databyte2 = b; if4.start = 1'b1;
      q4.push_back(f);
    end else begin
      if1.command = c; if1.databyte1 = a; if1.databyte2 = b; if1.start = 1'b1;
      q1.push_back(f);
    end
    @(posedge clk);
    #1;
    if (d == 0) if4.start = 1'b0;
    else        if1.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int n = 0;
    while (done_cnt[d] < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(done_cnt[d] >= target, "done_timeout", done_cnt[d], target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 24'hA53C0F};
    vecs[1] = '{8'h01, 8'h12, 8'h34, 24'h011234};
    vecs[2] = '{8'hFF, 8'h00, 8'h80, 24'hFF0080};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 24'h000000};
    vecs[4] = '{8'h80, 8'h01, 8'hFE, 24'h8001FE};

    rst4 = 1'b0; rst1 = 1'b0;
    if4.start = 1'b0; if4.command = 8'h00; if4.databyte1 = 8'h00; if4.databyte2 = 8'h00;
    if1.start = 1'b0; if1.command = 8'h00; if1.databyte1 = 8'h00; if1.databyte2 = 8'h00;
    cyc(3);
    rst4 = 1'b1; rst1 = 1'b1;
    cyc(3);

    for (int i = 0; i < 5; i++) begin
      base = done_cnt[0];
      send(0, vecs[i].cmd, vecs[i].d1, vecs[i].d2, vecs[i].frame);
      wait_done(0, base + 1, 300);
      cyc(60);
    end

    // start re-pulsed mid-frame and inputs cleared after accept
    base = done_cnt[0];
    send(0, 8'h69, 8'h96, 8'hC3, 24'h6996C3);
    cyc(4);
    if4.command = 8'h00; if4.databyte1 = 8'h00; if4.databyte2 = 8'h00;
    cyc(5);
    if4.start = 1'b1; cyc(1); if4.start = 1'b0;
    cyc(89);
    if4.start = 1'b1; cyc(1); if4.start = 1'b0;
    wait_done(0, base + 1, 300);
    cyc(60);
    chk(done_cnt[0] == base + 1, "repulse_one_frame", done_cnt[0], base + 1);
    chk(q4.size() == 0, "repulse_queue", q4.size(), 32'd0);

    // back-to-back frames with start held high
    base = done_cnt[0];
    gmin = 1000; gmax = 0; gap_n = 0;
    if4.command = 8'hC3; if4.databyte1 = 8'h5A; if4.databyte2 = 8'h69;
    repeat (3) q4.push_back(24'hC35A69);
    if4.start = 1'b1;
    wait_done(0, base + 2, 700);
    if4.start = 1'b0;
    wait_done(0, base + 3, 300);
    cyc(60);
    chk(done_cnt[0] == base + 3, "b2b_done_count", done_cnt[0], base + 3);
    chk(gap_n == 2, "b2b_gap_count", gap_n, 32'd2);
    chk(gmin == 1 && gmax == 1, "b2b_gap_len", gmax, 32'd1);

    // asynchronous reset at cycle 77 of a frame
    base = done_cnt[0];
    send(0, 8'h3C, 8'hA5, 8'hF0, 24'h3CA5F0);
    cyc(76);
    #2;
    rst4 = 1'b0;
    #1;
    chk({if4.cs, if4.sck, if4.sdo, if4.busy, if4.done} == 5'b0, "async_reset",
        {27'd0, if4.cs, if4.sck, if4.sdo, if4.busy, if4.done}, 32'd0);
    cyc(3);
    chk(q4.size() == 0, "reset_abandon", q4.size(), 32'd0);
    rst4 = 1'b1;
    cyc(5);
    chk(if4.cs == 1'b0, "no_resume", {31'd0, if4.cs}, 32'd0);
    chk(done_cnt[0] == base, "reset_no_done", done_cnt[0], base);
    send(0, 8'h96, 8'h5A, 8'h3C, 24'h965A3C);
    wait_done(0, base + 1, 300);
    cyc(60);

    // CLK_DIV = 1 instance
    base = done_cnt[1];
    send(1, 8'h5A, 8'hC3, 8'h96, 24'h5AC396);
    wait_done(1, base + 1, 100);
    cyc(10);
    base = done_cnt[1];
    send(1, 8'hFF, 8'h00, 8'h80, 24'hFF0080);
    wait_done(1, base + 1, 100);
    cyc(10);

    chk(q4.size() == 0, "q4_empty", q4.size(), 32'd0);
    chk(q1.size() == 0, "q1_empty", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
